// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM state encoding and common constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FS_BOOT    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_WAIT    = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage : pipeline_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count register: clear has priority, increments stop at CNT_MAX.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, the imem request handshake and the IF/ID
// load/flush/bubble controls. Taken branches redirect fetch; a response still
// in flight for the old address is drained and dropped in DISCARD.
module fetch_sequencer
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  output logic             imem_read,
  input  logic             imem_busywait,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             hold,
  input  logic             dmem_busywait,
  output logic [31:0]      fetch_pc,
  output logic [31:0]      fetch_pc_4,
  output logic             ifid_load,
  output logic             ifid_flush,
  output logic             ifid_bubble,
  output logic [CNT_W-1:0] imem_stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  req_addr;
  logic         stall_inc;
  logic         redirect_inc;
  logic         front_stall;

  assign front_stall = hold | dmem_busywait;

  // State, PC and outstanding-request address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FS_BOOT;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      // The address of the request on the bus is remembered so DISCARD can keep
      // presenting it unchanged while the redirected pc waits.
      if (state == FS_FETCH || state == FS_WAIT) begin
        req_addr <= pc;
      end
    end
  end

  // Next-state, next-pc and IF/ID control decode with branch > stall > miss > hit priority.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    imem_read    = 1'b0;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_bubble  = 1'b0;
    redirect_inc = 1'b0;
    unique case (state)
      FS_BOOT: begin
        state_next = FS_FETCH;
      end
      FS_FETCH, FS_WAIT: begin
        imem_read = 1'b1;
        if (branch_taken) begin
          pc_next      = branch_target;
          ifid_flush   = 1'b1;
          redirect_inc = 1'b1;
          state_next   = imem_busywait ? FS_DISCARD : FS_FETCH;
        end else if (front_stall) begin
          state_next = imem_busywait ? FS_WAIT : FS_FETCH;
        end else if (imem_busywait) begin
          ifid_bubble = 1'b1;
          state_next  = FS_WAIT;
        end else begin
          ifid_load  = 1'b1;
          pc_next    = pc + PC_STEP;
          state_next = FS_FETCH;
        end
      end
      FS_DISCARD: begin
        imem_read = 1'b1;
        if (branch_taken) begin
          pc_next      = branch_target;
          ifid_flush   = 1'b1;
          redirect_inc = 1'b1;
        end else if (!front_stall) begin
          ifid_bubble = 1'b1;
        end
        state_next = imem_busywait ? FS_DISCARD : FS_FETCH;
      end
      default: begin
        state_next = FS_BOOT;
      end
    endcase
  end

  assign imem_addr  = (state == FS_DISCARD) ? req_addr : pc;
  assign fetch_pc   = pc;
  assign fetch_pc_4 = pc + PC_STEP;
  assign stall_inc  = (state == FS_WAIT) || (state == FS_DISCARD);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (imem_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect_inc),
    .clear (1'b0),
    .count (redirect_cnt)
  );

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a cycle-level reference model checked on every
// negative edge, plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      imem_addr;
  logic             imem_read;
  logic             imem_busywait = 1'b0;
  logic             branch_taken = 1'b0;
  logic [31:0]      branch_target = 32'h0;
  logic             hold = 1'b0;
  logic             dmem_busywait = 1'b0;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_4;
  logic             ifid_load;
  logic             ifid_flush;
  logic             ifid_bubble;
  logic [CNT_W-1:0] imem_stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_read      (imem_read),
    .imem_busywait  (imem_busywait),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .hold           (hold),
    .dmem_busywait  (dmem_busywait),
    .fetch_pc       (fetch_pc),
    .fetch_pc_4     (fetch_pc_4),
    .ifid_load      (ifid_load),
    .ifid_flush     (ifid_flush),
    .ifid_bubble    (ifid_bubble),
    .imem_stall_cnt (imem_stall_cnt),
    .redirect_cnt   (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: "booted" after the first post-reset cycle, "discarding"
  // while an abandoned request drains, "miss_prev" when the previous active
  // cycle saw busywait (so this cycle is spent stalled on imem).
  bit          m_booted, m_discard, m_miss;
  logic [31:0] m_pc, m_old;
  int          m_stall, m_redir;
  bit          n_booted, n_discard, n_miss;
  logic [31:0] n_pc, n_old;
  int          n_stall, n_redir;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_booted <= 1'b0; m_discard <= 1'b0; m_miss <= 1'b0;
      m_pc <= RESET_PC; m_old <= RESET_PC; m_stall <= 0; m_redir <= 0;
    end else begin
      m_booted <= n_booted; m_discard <= n_discard; m_miss <= n_miss;
      m_pc <= n_pc; m_old <= n_old; m_stall <= n_stall; m_redir <= n_redir;
    end
  end

  always @(negedge clk) begin
    logic        e_read, e_load, e_flush, e_bubble;
    logic [31:0] e_addr;
    e_read = 1'b0; e_load = 1'b0; e_flush = 1'b0; e_bubble = 1'b0;
    e_addr = m_pc;
    n_booted = m_booted; n_discard = m_discard; n_miss = m_miss;
    n_pc = m_pc; n_old = m_old; n_stall = m_stall; n_redir = m_redir;
    if (!reset) begin
      if (!m_booted) begin
        n_booted = 1'b1;
      end else begin
        e_read  = 1'b1;
        n_stall = sat(m_stall + (m_miss ? 1 : 0));
        n_miss  = imem_busywait;
        if (m_discard) begin
          e_addr = m_old;
          if (branch_taken) begin
            e_flush = 1'b1; n_pc = branch_target; n_redir = sat(m_redir + 1);
          end else if (!(hold || dmem_busywait)) begin
            e_bubble = 1'b1;
          end
          n_discard = imem_busywait;
        end else begin
          n_old = m_pc;
          if (branch_taken) begin
            e_flush = 1'b1; n_pc = branch_target; n_redir = sat(m_redir + 1);
            n_discard = imem_busywait;
          end else if (hold || dmem_busywait) begin
            // IF/ID untouched; the same address is presented again.
          end else if (imem_busywait) begin
            e_bubble = 1'b1;
          end else begin
            e_load = 1'b1; n_pc = m_pc + 32'd4;
          end
        end
      end
    end
    check("m_imem_read", {31'b0, imem_read}, {31'b0, e_read});
    check("m_imem_addr", imem_addr, e_addr);
    check("m_fetch_pc", fetch_pc, m_pc);
    check("m_fetch_pc_4", fetch_pc_4, m_pc + 32'd4);
    check("m_ifid_ctl", {29'b0, ifid_load, ifid_flush, ifid_bubble},
          {29'b0, e_load, e_flush, e_bubble});
    check("m_stall_cnt", 32'(imem_stall_cnt), 32'(m_stall));
    check("m_redirect_cnt", 32'(redirect_cnt), 32'(m_redir));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string name, input logic ld, input logic fl, input logic bb);
    check(name, {29'b0, ifid_load, ifid_flush, ifid_bubble}, {29'b0, ld, fl, bb});
  endtask

  task automatic drive(input logic busy, input logic br, input logic [31:0] tgt,
                       input logic hd, input logic dm);
    imem_busywait = busy; branch_taken = br; branch_target = tgt;
    hold = hd; dmem_busywait = dm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_read", {31'b0, imem_read}, 32'd0);
    check("rst_pc", fetch_pc, 32'h0);
    check("rst_pc_4", fetch_pc_4, 32'h4);
    ctl("rst_ctl", 0, 0, 0);
    check("rst_cnts", {imem_stall_cnt, redirect_cnt}, 32'd0);

    // 1: boot cycle then back-to-back hits
    next_cycle(); reset = 1'b0;
    @(negedge clk); check("boot_read", {31'b0, imem_read}, 32'd0);
    next_cycle(); @(negedge clk); check("hit0_addr", imem_addr, 32'h0); ctl("hit0", 1, 0, 0);
    next_cycle(); @(negedge clk); check("hit4_addr", imem_addr, 32'h4); ctl("hit4", 1, 0, 0);

    // 2: three-cycle miss at 0x8
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drive(1, 0, 0, 0, 0);
      @(negedge clk); check("miss_addr", imem_addr, 32'h8); ctl("miss_ctl", 0, 0, 1);
    end
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); check("miss_done_addr", imem_addr, 32'h8); ctl("miss_done", 1, 0, 0);
    next_cycle(); @(negedge clk);
    check("hitc_addr", imem_addr, 32'hC); ctl("hitc", 1, 0, 0);
    check("stall3", 32'(imem_stall_cnt), 32'd3);

    // 3: redirect on a hit at 0x10
    next_cycle(); drive(0, 1, 32'h100, 0, 0);
    @(negedge clk); check("br_hit_addr", imem_addr, 32'h10); ctl("br_hit", 0, 1, 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); check("tgt_addr", imem_addr, 32'h100); ctl("tgt", 1, 0, 0);
    check("redir1", 32'(redirect_cnt), 32'd1);

    // 4: redirect while waiting at 0x14, old response drained
    next_cycle(); drive(0, 1, 32'h14, 0, 0);
    next_cycle(); drive(1, 0, 0, 0, 0);
    @(negedge clk); check("wait14_addr", imem_addr, 32'h14);
    next_cycle(); drive(1, 1, 32'h200, 0, 0);
    @(negedge clk); ctl("br_wait", 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); drive(1, 0, 0, 0, 0);
      @(negedge clk); check("disc_addr", imem_addr, 32'h14); ctl("disc", 0, 0, 1);
    end
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); check("disc_end_addr", imem_addr, 32'h14); ctl("disc_end", 0, 0, 1);
    next_cycle(); @(negedge clk);
    check("t200_addr", imem_addr, 32'h200); ctl("t200", 1, 0, 0);
    check("stall7", 32'(imem_stall_cnt), 32'd7);
    check("redir3", 32'(redirect_cnt), 32'd3);

    // 5: hold / dmem stall at 0x20, then hold together with a branch
    next_cycle(); drive(0, 1, 32'h20, 0, 0);
    next_cycle(); drive(0, 0, 0, 1, 0);
    @(negedge clk); check("hold_pc", fetch_pc, 32'h20); ctl("hold", 0, 0, 0);
    next_cycle(); drive(0, 0, 0, 1, 1);
    @(negedge clk); check("dmem_pc", fetch_pc, 32'h20); ctl("dmem", 0, 0, 0);
    next_cycle(); drive(0, 1, 32'h300, 1, 0);
    @(negedge clk); ctl("hold_br", 0, 1, 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); check("t300_addr", imem_addr, 32'h300);

    // PC wraps from the top word to zero
    next_cycle(); drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); check("top_pc_4", fetch_pc_4, 32'h0); ctl("top", 1, 0, 0);
    next_cycle(); @(negedge clk); check("wrap_addr", imem_addr, 32'h0);

    // newest redirect wins during DISCARD; hold suppresses the bubble there
    next_cycle(); drive(1, 1, 32'h400, 0, 0);
    next_cycle(); drive(1, 1, 32'h500, 0, 0);
    @(negedge clk); check("disc_br_addr", imem_addr, 32'h4); ctl("disc_br", 0, 1, 0);
    next_cycle(); drive(0, 0, 0, 1, 0);
    @(negedge clk); ctl("disc_hold", 0, 0, 0);
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); check("t500_addr", imem_addr, 32'h500);
    check("redir8", 32'(redirect_cnt), 32'd8);
    check("stall9", 32'(imem_stall_cnt), 32'd9);

    // counter saturation
    for (int i = 0; i < 10; i++) begin
      next_cycle(); drive(1, 0, 0, 0, 0);
    end
    next_cycle(); drive(0, 0, 0, 0, 0);
    next_cycle(); @(negedge clk);
    check("stall_sat", 32'(imem_stall_cnt), 32'(CNT_MAX));
    check("sat_addr", imem_addr, 32'h508);
    for (int i = 0; i < 10; i++) begin
      next_cycle(); drive(0, 1, 32'h600, 0, 0);
    end
    next_cycle(); drive(0, 0, 0, 0, 0);
    @(negedge clk); check("redir_sat", 32'(redirect_cnt), 32'(CNT_MAX));

    // 6: asynchronous reset in the middle of a WAIT
    next_cycle(); drive(1, 0, 0, 0, 0);
    next_cycle();
    #2 reset = 1'b1;
    #1;
    check("arst_read", {31'b0, imem_read}, 32'd0);
    check("arst_pc", fetch_pc, RESET_PC);
    check("arst_cnts", {imem_stall_cnt, redirect_cnt}, 32'd0);
    ctl("arst_ctl", 0, 0, 0);
    next_cycle(); drive(0, 0, 0, 0, 0); reset = 1'b0;
    @(negedge clk); check("reboot_read", {31'b0, imem_read}, 32'd0);
    next_cycle(); @(negedge clk);
    check("refetch_addr", imem_addr, RESET_PC); ctl("refetch", 1, 0, 0);

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_sequencer
